// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions: byte width, default code geometry and
// the sequencer state encoding.
package rs_pkg;

    localparam int RS_BYTE_W  = 8;
    localparam int RS_MSG_LEN = 223;
    localparam int RS_PAR_LEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MSG    = 3'd1,
        ST_PAD    = 3'd2,
        ST_PARITY = 3'd3
    } rs_state_e;

endpackage

// File: rtl/rs_seq_out_reg.sv
// Registered valid/ready output stage for the codeword stream; o_adv says
// whether the stage can take a new byte this cycle.
module rs_seq_out_reg
    import rs_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_load,
    input  logic [RS_BYTE_W-1:0] i_data,
    input  logic                 i_ready,
    output logic [RS_BYTE_W-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_adv
);

    logic [RS_BYTE_W-1:0] r_data;
    logic                 r_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_adv   = !r_valid || i_ready;

endmodule

// File: rtl/rs_encoder_sequencer.sv
// Drives an RS encoder from the Rx byte stream and emits message+parity
// codewords with zero padding on timeout. Optional stats: RS_SEQ_STATS_EN.
module rs_encoder_sequencer
    import rs_pkg::*;
#(
    parameter int MSG_LEN = RS_MSG_LEN,
    parameter int PAR_LEN = RS_PAR_LEN,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [RS_BYTE_W-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 enc_start,
    output logic                 enc_ce,
    output logic [RS_BYTE_W-1:0] enc_data,
    output logic                 enc_flush,
    input  logic [RS_BYTE_W-1:0] enc_parity,
    output logic [RS_BYTE_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef RS_SEQ_STATS_EN
    output logic [15:0]          blk_count,
    output logic [15:0]          pad_count,
`endif
    output logic                 busy
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(PAR_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    rs_state_e            r_state, w_state_next;
    logic [CNT_W-1:0]     r_byte_cnt, w_byte_cnt_next;
    logic [TMO_W-1:0]     r_tmo_cnt, w_tmo_cnt_next;
    logic                 w_adv;
    logic                 w_load;
    logic [RS_BYTE_W-1:0] w_load_data;
    logic                 w_pad_enter;
    logic                 w_blk_done;

    rs_seq_out_reg u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_ready (out_ready),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_adv   (w_adv)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_tmo_cnt  <= w_tmo_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_tmo_cnt_next  = r_tmo_cnt;
        rx_ready        = 1'b0;
        enc_start       = 1'b0;
        enc_ce          = 1'b0;
        enc_data        = '0;
        enc_flush       = 1'b0;
        w_load          = 1'b0;
        w_load_data     = '0;
        w_pad_enter     = 1'b0;
        w_blk_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated so a pending rx byte cannot pulse enc_start while held in reset
                if (rx_valid) begin
                    enc_start    = reset_n;
                    w_state_next = ST_MSG;
                end
            end
            ST_MSG: begin
                rx_ready = w_adv;
                if (w_adv) begin
                    if (rx_valid) begin
                        enc_ce         = 1'b1;
                        enc_data       = rx_data;
                        w_load         = 1'b1;
                        w_load_data    = rx_data;
                        w_tmo_cnt_next = '0;
                        if (r_byte_cnt == MSG_LAST) begin
                            w_byte_cnt_next = '0;
                            w_state_next    = ST_PARITY;
                        end else begin
                            w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
                        end
                    end else if (r_byte_cnt != '0) begin
                        // Idle time only counts once the block holds at least one byte
                        if (r_tmo_cnt == TMO_LAST) begin
                            w_tmo_cnt_next = '0;
                            w_state_next   = ST_PAD;
                            w_pad_enter    = 1'b1;
                        end else begin
                            w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
                        end
                    end
                end
            end
            ST_PAD: begin
                if (w_adv) begin
                    enc_ce = 1'b1;
                    w_load = 1'b1;
                    if (r_byte_cnt == MSG_LAST) begin
                        w_byte_cnt_next = '0;
                        w_state_next    = ST_PARITY;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_adv) begin
                    enc_ce      = 1'b1;
                    enc_flush   = 1'b1;
                    w_load      = 1'b1;
                    w_load_data = enc_parity;
                    if (r_byte_cnt == PAR_LAST) begin
                        w_byte_cnt_next = '0;
                        w_state_next    = ST_IDLE;
                        w_blk_done      = 1'b1;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

`ifdef RS_SEQ_STATS_EN
    logic [15:0] r_blk_count;
    logic [15:0] r_pad_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blk_count <= '0;
            r_pad_count <= '0;
        end else begin
            if (w_blk_done)  r_blk_count <= r_blk_count + 16'd1;
            if (w_pad_enter) r_pad_count <= r_pad_count + 16'd1;
        end
    end

    assign blk_count = r_blk_count;
    assign pad_count = r_pad_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_pad_enter ^ w_blk_done;
`endif

endmodule

// File: tb/tb_rs_encoder_sequencer.sv
// Directed bench for rs_encoder_sequencer with a behavioural RS(6,4) encoder
// (generator (x+1)(x+2) over GF(256), poly 0x11d) driving enc_parity.
module tb_rs_encoder_sequencer;

    localparam int MSG_LEN = 4;
    localparam int PAR_LEN = 2;
    localparam int TIMEOUT = 8;
    localparam int CW_LEN  = MSG_LEN + PAR_LEN;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       enc_start;
    logic       enc_ce;
    logic [7:0] enc_data;
    logic       enc_flush;
    logic [7:0] enc_parity;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
`ifdef RS_SEQ_STATS_EN
    logic [15:0] blk_count;
    logic [15:0] pad_count;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rs_encoder_sequencer #(
        .MSG_LEN (MSG_LEN),
        .PAR_LEN (PAR_LEN),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .enc_start  (enc_start),
        .enc_ce     (enc_ce),
        .enc_data   (enc_data),
        .enc_flush  (enc_flush),
        .enc_parity (enc_parity),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef RS_SEQ_STATS_EN
        .blk_count  (blk_count),
        .pad_count  (pad_count),
`endif
        .busy       (busy)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, r;
        a = a_in; b = b_in; r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) r = r ^ a;
            b = b >> 1;
            a = a[7] ? ((a << 1) ^ 8'h1d) : (a << 1);
        end
        return r;
    endfunction

    // Reference encoder: cleared by enc_start, parity shifted out highest first
    logic [7:0] p1 = 8'h00;
    logic [7:0] p0 = 8'h00;
    assign enc_parity = p1;

    always @(posedge clk) begin
        if (enc_start) begin
            p1 <= 8'h00;
            p0 <= 8'h00;
        end else if (enc_ce) begin
            if (enc_flush) begin
                p1 <= p0;
                p0 <= 8'h00;
            end else begin
                p1 <= p0 ^ gf_mul(enc_data ^ p1, 8'h03);
                p0 <= gf_mul(enc_data ^ p1, 8'h02);
            end
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge
    logic [7:0] got[$];
    int n_start = 0;
    int n_ce = 0;
    int n_flush = 0;
    int n_ce_stall = 0;

    always @(negedge clk) begin
        if (enc_start) n_start++;
        if (enc_ce) n_ce++;
        if (enc_ce && enc_flush) n_flush++;
        if (enc_ce && out_valid && !out_ready) n_ce_stall++;
        if (out_valid && out_ready) got.push_back(out_data);
    end

    bit rand_en = 1'b0;
    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic clear_mon();
        got.delete();
        n_start = 0; n_ce = 0; n_flush = 0; n_ce_stall = 0;
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL send_accept: byte %02h never accepted (required rx_ready within 300 cycles)", b);
        end
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = !busy && !out_valid;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_idle: busy=%0b out_valid=%0b after 500 cycles, required 0/0", busy, out_valid);
        end
    endtask

    function automatic logic [7:0] synd(input int first, input logic [7:0] root);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < CW_LEN; i++) s = gf_mul(s, root) ^ got[first + i];
        return s;
    endfunction

    task automatic check_block(input string name, input int first, input logic [7:0] m0,
                               input logic [7:0] m1, input logic [7:0] m2, input logic [7:0] m3);
        logic [7:0] exp_m[4];
        logic [7:0] s0, s1;
        exp_m[0] = m0; exp_m[1] = m1; exp_m[2] = m2; exp_m[3] = m3;
        for (int i = 0; i < MSG_LEN; i++) begin
            total++;
            if (got[first + i] !== exp_m[i]) begin
                bad++;
                $display("FAIL %s msg[%0d]: got %02h required %02h", name, i, got[first + i], exp_m[i]);
            end
        end
        s0 = synd(first, 8'h01);
        s1 = synd(first, 8'h02);
        total++;
        if (s0 !== 8'h00 || s1 !== 8'h00) begin
            bad++;
            $display("FAIL %s syndrome: got S0=%02h S1=%02h required 00/00", name, s0, s1);
        end
        $display("%s: codeword %02h %02h %02h %02h | %02h %02h", name, got[first], got[first+1],
                 got[first+2], got[first+3], got[first+4], got[first+5]);
    endtask

    task automatic test_reset();
        rx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({rx_ready, enc_start, enc_ce, enc_data, enc_flush, out_data, out_valid, busy} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: rx_ready=%0b start=%0b ce=%0b ed=%02h fl=%0b od=%02h ov=%0b busy=%0b required all 0",
                     rx_ready, enc_start, enc_ce, enc_data, enc_flush, out_data, out_valid, busy);
        end
`ifdef RS_SEQ_STATS_EN
        total++;
        if (blk_count !== 16'd0 || pad_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_stats: blk=%0d pad=%0d required 0/0", blk_count, pad_count);
        end
`endif
        rx_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%0b rx_ready=%0b required 0/0", busy, rx_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_cw[6];
        exp_cw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h00};
        clear_mon();
        out_ready = 1'b1;
        send(8'h11);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            bad++;
            $display("FAIL basic_latency: out_valid=%0b out_data=%02h required 1/11", out_valid, out_data);
        end
        send(8'h22);
        send(8'h33);
        send(8'h44);
        wait_idle();
        total++;
        if (n_start !== 1 || n_ce !== CW_LEN || n_flush !== PAR_LEN) begin
            bad++;
            $display("FAIL basic_counts: start=%0d ce=%0d flush=%0d required 1/%0d/%0d",
                     n_start, n_ce, n_flush, CW_LEN, PAR_LEN);
        end
        total++;
        if (got.size() !== CW_LEN) begin
            bad++;
            $display("FAIL basic_len: got %0d bytes required %0d", got.size(), CW_LEN);
        end
        for (int i = 0; i < CW_LEN; i++) begin
            total++;
            if (got[i] !== exp_cw[i]) begin
                bad++;
                $display("FAIL basic_byte[%0d]: got %02h required %02h", i, got[i], exp_cw[i]);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy: got %0b required 0", busy);
        end
        check_block("basic", 0, 8'h11, 8'h22, 8'h33, 8'h44);
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        clear_mon();
        out_ready = 1'b1;
        send(8'hAA);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (enc_ce) early++;
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL timeout_early: %0d enc_ce cycles before timeout, required 0", early);
        end
        @(negedge clk);
        total++;
        if (enc_ce !== 1'b1 || enc_data !== 8'h00 || enc_flush !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pad_start: ce=%0b data=%02h flush=%0b required 1/00/0", enc_ce, enc_data, enc_flush);
        end
        wait_idle();
        total++;
        if (got.size() !== CW_LEN || n_start !== 1) begin
            bad++;
            $display("FAIL timeout_len: got %0d bytes %0d starts required %0d/1", got.size(), n_start, CW_LEN);
        end
        check_block("timeout", 0, 8'hAA, 8'h00, 8'h00, 8'h00);
`ifdef RS_SEQ_STATS_EN
        total++;
        if (pad_count !== 16'd1) begin
            bad++;
            $display("FAIL timeout_pad_count: got %0d required 1", pad_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        int rdy_hi;
        rdy_hi = 0;
        clear_mon();
        out_ready = 1'b1;
        send(8'h5A);
        send(8'hC3);
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_ready) rdy_hi++;
        end
        total++;
        if (rdy_hi !== 0 || n_ce_stall !== 0 || n_ce !== 2) begin
            bad++;
            $display("FAIL stall_hold: rx_ready_hi=%0d ce_in_stall=%0d ce=%0d required 0/0/2", rdy_hi, n_ce_stall, n_ce);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h77);
        send(8'h88);
        wait_idle();
        total++;
        if (got.size() !== CW_LEN || n_ce !== CW_LEN) begin
            bad++;
            $display("FAIL stall_len: got %0d bytes %0d ce required %0d/%0d", got.size(), n_ce, CW_LEN, CW_LEN);
        end
        check_block("stall", 0, 8'h5A, 8'hC3, 8'h77, 8'h88);
    endtask

    task automatic test_parity_pending();
        int rdy_hi;
        rdy_hi = 0;
        clear_mon();
        out_ready = 1'b1;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        rx_data = 8'hE7;
        rx_valid = 1'b1;
        for (int i = 0; i < PAR_LEN; i++) begin
            @(negedge clk);
            if (rx_ready) rdy_hi++;
        end
        total++;
        if (rdy_hi !== 0) begin
            bad++;
            $display("FAIL pending_rx_ready: high %0d cycles in PARITY required 0", rdy_hi);
        end
        @(negedge clk);
        total++;
        if (enc_start !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL pending_restart: start=%0b rx_ready=%0b busy=%0b required 1/0/0", enc_start, rx_ready, busy);
        end
        send(8'hE7); send(8'h9C); send(8'h3D); send(8'h00);
        wait_idle();
        total++;
        if (got.size() !== 2 * CW_LEN || n_start !== 2) begin
            bad++;
            $display("FAIL pending_len: got %0d bytes %0d starts required %0d/2", got.size(), n_start, 2 * CW_LEN);
        end
        check_block("pending_a", 0, 8'h01, 8'h02, 8'h03, 8'h04);
        check_block("pending_b", CW_LEN, 8'hE7, 8'h9C, 8'h3D, 8'h00);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(8'hDE);
        send(8'hAD);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({rx_ready, enc_start, enc_ce, enc_data, enc_flush, out_data, out_valid, busy} !== 21'd0) begin
            bad++;
            $display("FAIL midreset_async: rx_ready=%0b start=%0b ce=%0b ed=%02h fl=%0b od=%02h ov=%0b busy=%0b required all 0",
                     rx_ready, enc_start, enc_ce, enc_data, enc_flush, out_data, out_valid, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        clear_mon();
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        wait_idle();
        total++;
        if (got.size() !== CW_LEN || n_start !== 1) begin
            bad++;
            $display("FAIL midreset_len: got %0d bytes %0d starts required %0d/1", got.size(), n_start, CW_LEN);
        end
        check_block("midreset", 0, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    endtask

    task automatic test_random();
        logic [7:0] m[4];
        rand_en = 1'b1;
        for (int blk = 0; blk < 50; blk++) begin
            clear_mon();
            for (int i = 0; i < MSG_LEN; i++) m[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < MSG_LEN; i++) send(m[i]);
            wait_idle();
            total++;
            if (got.size() !== CW_LEN || n_ce_stall !== 0) begin
                bad++;
                $display("FAIL random_len blk %0d: got %0d bytes, %0d stalled ce, required %0d/0",
                         blk, got.size(), n_ce_stall, CW_LEN);
            end
            check_block($sformatf("random%0d", blk), 0, m[0], m[1], m[2], m[3]);
        end
        rand_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_backpressure();
        test_parity_pending();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
